// File: rtl/framebuffer_prefetch.sv
// Pixel prefetch between the RP2040 framebuffer pins and the VGA core.
// Credit-limited strobes feed a first-word-fall-through gray-pixel FIFO.
module framebuffer_prefetch #(
    parameter int DEPTH       = 4,
    parameter int PIXEL_WIDTH = 4,
    parameter int LATENCY     = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_start,
    input  logic                   pixel_req,
    output logic [PIXEL_WIDTH-1:0] pixel_out,
    output logic                   pixel_valid,
    output logic                   underrun,
    output logic                   frame_next_pixel_out,
    output logic                   frame_reset_out,
    input  logic [PIXEL_WIDTH-1:0] frame_pixel_in
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, REWIND, STREAM} state_t;

    state_t                 state_q, state_d;
    logic                   rw_cnt_q, rw_cnt_d;
    logic                   strobe, strobe_q;
    logic [LATENCY-1:0]     sr_q, sr_d;
    logic [AW-1:0]          wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]            occ_q, occ_d;
    logic                   und_q, und_d;
    logic [PIXEL_WIDTH-1:0] mem_q [DEPTH];
    logic                   flush, push, pop, valid;
    logic [31:0]            pending;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            rw_cnt_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rw_cnt_q <= rw_cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        rw_cnt_d = rw_cnt_q;
        if (frame_start) begin
            state_d  = REWIND;
            rw_cnt_d = 1'b0;
        end else if (state_q == REWIND) begin
            if (rw_cnt_q) begin
                state_d  = STREAM;
                rw_cnt_d = 1'b0;
            end else begin
                rw_cnt_d = 1'b1;
            end
        end
    end

    // Pixels already in the FIFO plus those still in the RP2040 pipe.
    always_comb begin
        pending = 32'(occ_q);
        for (int i = 0; i < LATENCY; i++) begin
            pending = pending + 32'(sr_q[i]);
        end
    end

    always_comb begin
        frame_reset_out = (state_q == REWIND);
        strobe = (state_q == STREAM) && !frame_start && !strobe_q
                 && (pending < 32'(DEPTH));
    end

    assign frame_next_pixel_out = strobe;

    always_comb begin
        flush = frame_start || (state_q == REWIND);
        valid = (occ_q != '0);
        push  = sr_q[LATENCY-1] && !flush;
        pop   = pixel_req && valid && !flush;
        sr_d  = flush ? '0 : ((sr_q << 1) | LATENCY'(strobe));
        wr_d  = wr_q;
        rd_d  = rd_q;
        occ_d = occ_q;
        if (push) wr_d = wr_q + AW'(1);
        if (pop)  rd_d = rd_q + AW'(1);
        if (push && !pop) occ_d = occ_q + (AW+1)'(1);
        if (pop && !push) occ_d = occ_q - (AW+1)'(1);
        und_d = und_q || (pixel_req && !valid);
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            occ_d = '0;
            und_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strobe_q <= 1'b0;
            sr_q     <= '0;
            wr_q     <= '0;
            rd_q     <= '0;
            occ_q    <= '0;
            und_q    <= 1'b0;
        end else begin
            strobe_q <= strobe;
            sr_q     <= sr_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            occ_q    <= occ_d;
            und_q    <= und_d;
        end
    end

    // Storage needs no reset: pixel_out is gated by occupancy.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= frame_pixel_in;
    end

    assign pixel_valid = valid;
    assign pixel_out   = valid ? mem_q[rd_q] : '0;
    assign underrun    = und_q;

endmodule

// File: tb/tb_framebuffer_prefetch.sv
// Directed bench for framebuffer_prefetch with a small RP2040 responder.
// Timing: inputs change 1ns after posedge, outputs sampled 2ns after.
module tb_framebuffer_prefetch;

    localparam int DEPTH = 4;
    localparam int PW    = 4;
    localparam int LAT   = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          frame_start;
    logic          pixel_req;
    logic [PW-1:0] pixel_out;
    logic          pixel_valid;
    logic          underrun;
    logic          frame_next_pixel_out;
    logic          frame_reset_out;
    logic [PW-1:0] frame_pixel_in;

    int            checks = 0;
    int            errs   = 0;
    logic [PW-1:0] seq    = 4'h1;
    logic [PW-1:0] exp_px;
    logic [2:0]    hist   = '0;

    framebuffer_prefetch #(
        .DEPTH(DEPTH), .PIXEL_WIDTH(PW), .LATENCY(LAT)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .frame_start         (frame_start),
        .pixel_req           (pixel_req),
        .pixel_out           (pixel_out),
        .pixel_valid         (pixel_valid),
        .underrun            (underrun),
        .frame_next_pixel_out(frame_next_pixel_out),
        .frame_reset_out     (frame_reset_out),
        .frame_pixel_in      (frame_pixel_in)
    );

    always #5 clk = ~clk;

    // RP2040 model: answers a strobe LAT cycles later with the next number.
    always @(negedge clk) begin
        hist = {hist[1:0], frame_next_pixel_out};
        if (hist[2]) begin
            frame_pixel_in = seq;
            seq = seq + 4'h1;
        end else begin
            frame_pixel_in = '0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            assert (!(dut.push && !dut.pop && dut.occ_q == 3'(DEPTH)))
            else begin
                errs++;
                $error("FAIL overflow push into full fifo");
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nx();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1;
        frame_start = 1'b0;
        pixel_req = 1'b0;
        frame_pixel_in = '0;
        #12;
        chk("rst_out", 32'(pixel_out), 0);
        chk("rst_valid", 32'(pixel_valid), 0);
        chk("rst_underrun", 32'(underrun), 0);
        chk("rst_strobe", 32'(frame_next_pixel_out), 0);
        chk("rst_freset", 32'(frame_reset_out), 0);

        nx();
        rst = 1'b0;
        for (int c = 0; c <= 20; c++) begin
            if (c > 0) nx();
            frame_start = (c == 5);
            settle();
            chk($sformatf("strobe_c%0d", c), 32'(frame_next_pixel_out),
                32'(c == 8 || c == 10 || c == 12 || c == 14));
            chk($sformatf("freset_c%0d", c), 32'(frame_reset_out),
                32'(c == 6 || c == 7));
            chk($sformatf("valid_c%0d", c), 32'(pixel_valid), 32'(c >= 11));
            if (c == 11 || c == 20) chk("head_first", 32'(pixel_out), 1);
        end

        for (int c = 21; c <= 24; c++) begin
            nx();
            pixel_req = 1'b1;
            settle();
            chk($sformatf("pop_c%0d", c), 32'(pixel_out), 32'(c - 20));
            chk($sformatf("refill_c%0d", c), 32'(frame_next_pixel_out),
                32'(c == 22 || c == 24));
        end
        nx();
        pixel_req = 1'b0;
        settle();
        chk("after_pops_valid", 32'(pixel_valid), 1);
        chk("after_pops_out", 32'(pixel_out), 5);
        repeat (10) nx();

        exp_px = 4'h5;
        for (int i = 0; i < 100; i++) begin
            nx();
            pixel_req = 1'b1;
            settle();
            chk($sformatf("ss_valid_%0d", i), 32'(pixel_valid), 1);
            chk($sformatf("ss_data_%0d", i), 32'(pixel_out), 32'(exp_px));
            exp_px = exp_px + 4'h1;
            nx();
            pixel_req = 1'b0;
            nx();
        end
        chk("ss_underrun", 32'(underrun), 0);
        repeat (10) nx();

        nx();
        frame_start = 1'b1;
        pixel_req = 1'b1;
        settle();
        chk("prio_underrun", 32'(underrun), 0);
        chk("prio_strobe", 32'(frame_next_pixel_out), 0);
        nx();
        frame_start = 1'b0;
        pixel_req = 1'b0;
        seq = 4'h7;
        settle();
        chk("rw1_freset", 32'(frame_reset_out), 1);
        chk("rw1_valid", 32'(pixel_valid), 0);
        chk("rw1_underrun", 32'(underrun), 0);
        nx();
        settle();
        chk("rw2_freset", 32'(frame_reset_out), 1);
        nx();
        pixel_req = 1'b1;
        settle();
        chk("ur_strobe", 32'(frame_next_pixel_out), 1);
        chk("ur_valid", 32'(pixel_valid), 0);
        nx();
        pixel_req = 1'b0;
        settle();
        chk("ur_set", 32'(underrun), 1);
        chk("ur_out", 32'(pixel_out), 0);
        repeat (3) nx();
        settle();
        chk("ur_sticky", 32'(underrun), 1);

        nx();
        frame_start = 1'b1;
        settle();
        chk("fl_pre_valid", 32'(pixel_valid), 1);
        chk("fl_pre_out", 32'(pixel_out), 7);
        chk("fl_pre_underrun", 32'(underrun), 1);
        nx();
        frame_start = 1'b0;
        settle();
        chk("fl_valid", 32'(pixel_valid), 0);
        chk("fl_freset1", 32'(frame_reset_out), 1);
        chk("fl_underrun", 32'(underrun), 0);
        nx();
        seq = 4'hA;
        settle();
        chk("fl_freset2", 32'(frame_reset_out), 1);
        chk("fl_nostrobe", 32'(frame_next_pixel_out), 0);
        nx();
        settle();
        chk("fl_freset_end", 32'(frame_reset_out), 0);
        chk("fl_strobe", 32'(frame_next_pixel_out), 1);
        nx();
        settle();
        chk("fl_discard", 32'(pixel_valid), 0);
        nx();
        settle();
        chk("ar_pre_strobe", 32'(frame_next_pixel_out), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_strobe", 32'(frame_next_pixel_out), 0);
        chk("ar_freset", 32'(frame_reset_out), 0);
        chk("ar_valid", 32'(pixel_valid), 0);
        chk("ar_out", 32'(pixel_out), 0);
        nx();
        nx();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            nx();
            settle();
            chk($sformatf("ar_idle_strobe%0d", c),
                32'(frame_next_pixel_out), 0);
            chk($sformatf("ar_idle_valid%0d", c), 32'(pixel_valid), 0);
        end
        nx();
        frame_start = 1'b1;
        nx();
        frame_start = 1'b0;
        settle();
        chk("re_freset1", 32'(frame_reset_out), 1);
        nx();
        settle();
        chk("re_freset2", 32'(frame_reset_out), 1);
        nx();
        settle();
        chk("re_strobe", 32'(frame_next_pixel_out), 1);
        chk("re_freset_end", 32'(frame_reset_out), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errs);
        $finish;
    end

endmodule
